div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider used by the EX stage for DIV/DIVU.
- It is the requester side of the stall controller: it drives the EX stall request while a division is in flight.
- The stall controller answers by freezing PC, IF, ID and EX until the result is ready.
- Produces quotient and remainder for the HI/LO write path.

Parameters:
WIDTH, 32, operand width in bits; the result is 2*WIDTH bits; the step counter is clog2(WIDTH) bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start_i  input  1  EX holds a divide instruction; held high for as long as the stall persists
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start
opdata1_i  input  WIDTH  dividend; sampled at start
opdata2_i  input  WIDTH  divisor; sampled at start
annul_i  input  1  abort the current operation (exception or flush)
result_o  output  2*WIDTH  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO); registered
ready_o  output  1  result valid; registered one-cycle pulse
stallreq_o  output  1  combinational stall request to the stall controller

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0, working registers=0.
  - result_o=0, ready_o=0; stallreq_o follows its equation (0 unless start_i is high).
- States: IDLE, BYZERO, ON, END.
- stallreq_o = start_i & ~annul_i & (state != END). It is combinational so the stall takes effect in the start cycle.
- IDLE:
  - Condition: start_i & ~annul_i.
  - If opdata2_i == 0: go to BYZERO.
  - Otherwise go to ON with counter=0. Latch the operand magnitudes: two's-complement absolute value when signed_div_i=1 and the operand MSB=1, raw value otherwise.
  - Latch sign flags: quotient negative = signed & (msb1 ^ msb2); remainder negative = signed & msb1.
  - ready_o=0.
- BYZERO: next state END; result_o=0 (divide-by-zero result is fixed at 0).
- ON, each cycle:
  - Shift the partial remainder left by 1, bringing in the next dividend bit (MSB first).
  - If the partial remainder >= the divisor magnitude: subtract and set the quotient bit to 1; otherwise set it to 0.
  - Increment the counter.
  - After the WIDTH-th step (counter == WIDTH-1): apply sign correction (negate quotient and/or remainder per the latched flags), load result_o, go to END.
- END:
  - ready_o=1 for exactly this cycle and stallreq_o=0, so the pipeline advances.
  - Next state is always IDLE; ready_o returns to 0.
  - result_o holds until the next operation loads it.
- Latency (start sampled in cycle T):
  - Nonzero divisor: ON covers T+1..T+WIDTH, END at T+WIDTH+1 (T+33 for WIDTH=32); stallreq_o is high T..T+WIDTH.
  - Zero divisor: END at T+2.
- annul_i:
  - In IDLE, BYZERO or ON: return to IDLE next cycle, ready_o stays 0, result_o is unchanged.
  - In END: ignored.
- start_i dropping while in ON or BYZERO is treated as annul.
- Back-to-back divides: start_i stays high through END, then a new operation begins from IDLE in the following cycle.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap, no trap).
- No operand re-sampling occurs during ON; input changes are ignored until IDLE.

Test Plan:
1. Unsigned: start with opdata1=100, opdata2=7, signed=0 -> stallreq_o high for 33 cycles, ready_o pulses at T+33, result_o = {0x00000002, 0x0000000E}.
2. Signed: -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; also 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
3. Divide by zero: opdata2=0 -> ready_o at T+2, result_o = 0, stallreq_o high for 2 cycles only.
4. Annul: assert annul_i at T+10 -> stallreq_o low that cycle, state IDLE at T+11, no ready_o pulse, result_o keeps its prior value.
5. Overflow and back-to-back: signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}; start_i held through END -> second divide (0xFFFFFFFF / 0x10 unsigned = {0xF, 0x0FFFFFFF}) completes 34 cycles after the first END.
6. Reset mid-operation: assert rst asynchronously (off-edge) at T+15 -> result_o=0, ready_o=0 immediately; after release with start_i high, a fresh 33-cycle divide completes correctly.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// It raises a stall request until the HI/LO result is ready.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stallreq_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] dvd;      // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic             neg_q, neg_r;

   logic             go, abort, last, fits;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff, rem_nxt, quo_nxt, q_fix, r_fix;
   logic [WIDTH-1:0] mag1, mag2;

   assign go         = start_i & ~annul_i;
   assign abort      = annul_i | ~start_i;
   assign last       = (counter == CW'(WIDTH - 1));
   assign stallreq_o = start_i & ~annul_i & (state != END);

   assign mag1 = (signed_div_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign mag2 = (signed_div_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

   // One restoring step: partial remainder fits in WIDTH bits since it is always < divisor.
   assign rem_sh  = {rem, dvd[WIDTH-1]};
   assign fits    = (rem_sh >= {1'b0, dvs});
   assign diff    = rem_sh[WIDTH-1:0] - dvs;
   assign rem_nxt = fits ? diff : rem_sh[WIDTH-1:0];
   assign quo_nxt = {dvd[WIDTH-2:0], fits};
   assign q_fix   = neg_q ? -quo_nxt : quo_nxt;
   assign r_fix   = neg_r ? -rem_nxt : rem_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = (opdata2_i == '0) ? BYZERO : ON;
         BYZERO:  state_nxt = abort ? IDLE : END;
         ON: begin
            if (abort)     state_nxt = IDLE;
            else if (last) state_nxt = END;
         end
         END:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter  <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (go && opdata2_i != '0) begin
                  counter <= '0;
                  dvd     <= mag1;
                  dvs     <= mag2;
                  rem     <= '0;
                  neg_q   <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  neg_r   <= signed_div_i & opdata1_i[WIDTH-1];
               end
            end
            BYZERO: begin
               if (!abort) begin
                  result_o <= '0;
                  ready_o  <= 1'b1;
               end
            end
            ON: begin
               if (!abort) begin
                  rem     <= rem_nxt;
                  dvd     <= quo_nxt;
                  counter <= counter + CW'(1);
                  if (last) begin
                     result_o <= {r_fix, q_fix};
                     ready_o  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table, corner sequences and random divides vs. an arithmetic model.
module tb_div_unit;

   logic        clk, rst, start, sdiv, annul;
   logic [31:0] op1, op2;
   logic [63:0] result;
   logic        ready, stallreq;

   int checks = 0;
   int errors = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start_i(start), .signed_div_i(sdiv),
      .opdata1_i(op1), .opdata2_i(op2), .annul_i(annul),
      .result_o(result), .ready_o(ready), .stallreq_o(stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: 64-bit arithmetic on the (sign/zero-extended) operands, truncating division.
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Called at a negedge while the DUT is idle; returns at the negedge after END.
   task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string nm);
      int lat, stalls;
      sdiv = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
      #1;
      lat = -1; stalls = 0;
      for (int k = 0; k < 60; k++) begin
         if (ready) begin lat = k; break; end
         if (stallreq) stalls++;
         @(negedge clk);
      end
      chk({nm, " latency"}, 64'(lat), (b == 0) ? 64'd2 : 64'd33);
      chk({nm, " stall cycles"}, 64'(stalls), (b == 0) ? 64'd2 : 64'd33);
      chk({nm, " stall low at end"}, {63'd0, stallreq}, 64'd0);
      chk({nm, " result"}, result, exp);
      start = 1'b0;
      @(negedge clk);
      chk({nm, " ready pulse width"}, {63'd0, ready}, 64'd0);
   endtask

   task automatic no_ready(input string nm, input logic [63:0] keep);
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready) seen++;
      end
      chk({nm, " no ready"}, 64'(seen), 64'd0);
      chk({nm, " result kept"}, result, keep);
   endtask

   initial begin
      logic [63:0] prev;
      int          lat;

      vt[0] = '{1'b0, 32'd100,        32'd7,          {32'h2,        32'hE}};
      vt[1] = '{1'b1, 32'hFFFF_FFF9,  32'h2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
      vt[2] = '{1'b1, 32'h7,          32'hFFFF_FFFE,  {32'h1,        32'hFFFF_FFFD}};
      vt[3] = '{1'b0, 32'd5,          32'd0,          64'd0};
      vt[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,        32'h8000_0000}};
      vt[5] = '{1'b0, 32'hFFFF_FFFF,  32'h10,         {32'hF,        32'h0FFF_FFFF}};
      vt[6] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0,        32'h1}};
      vt[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0}};
      vt[8] = '{1'b0, 32'hFFFF_FFFF,  32'h1,          {32'h0,        32'hFFFF_FFFF}};

      rst = 1'b1; start = 1'b0; sdiv = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
      repeat (2) @(negedge clk);
      chk("reset result", result, 64'd0);
      chk("reset ready", {63'd0, ready}, 64'd0);
      chk("reset stallreq", {63'd0, stallreq}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++)
         do_div(vt[i].s, vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i));

      // Annul in ON at T+10
      prev = result;
      sdiv = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
      repeat (10) @(negedge clk);
      annul = 1'b1;
      #1 chk("annul stallreq", {63'd0, stallreq}, 64'd0);
      @(negedge clk);
      annul = 1'b0; start = 1'b0;
      no_ready("annul on", prev);

      // start_i dropping in ON behaves as annul
      start = 1'b1; op1 = 32'd77; op2 = 32'd5;
      repeat (5) @(negedge clk);
      start = 1'b0;
      no_ready("drop start", prev);

      // Annul in BYZERO
      start = 1'b1; op2 = 32'd0;
      @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0; start = 1'b0;
      no_ready("annul byzero", prev);

      // Back-to-back: start held through END
      sdiv = 1'b1; op1 = 32'h8000_0000; op2 = 32'hFFFF_FFFF; start = 1'b1;
      lat = -1;
      for (int k = 0; k < 60; k++) begin
         #1;
         if (ready) begin lat = k; break; end
         @(negedge clk);
      end
      chk("b2b first latency", 64'(lat), 64'd33);
      chk("b2b first result", result, {32'h0, 32'h8000_0000});
      sdiv = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'h10;
      lat = -1;
      for (int k = 1; k < 60; k++) begin
         @(negedge clk);
         if (ready) begin lat = k; break; end
      end
      chk("b2b second latency", 64'(lat), 64'd34);
      chk("b2b second result", result, {32'hF, 32'h0FFF_FFFF});

      // Asynchronous reset mid-operation, then a fresh divide with start held
      op1 = 32'd1234567; op2 = 32'd89;
      @(negedge clk);
      repeat (15) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst result", result, 64'd0);
      chk("async rst ready", {63'd0, ready}, 64'd0);
      #1 rst = 1'b0;
      lat = -1;
      for (int k = 1; k < 60; k++) begin
         @(negedge clk);
         if (ready) begin lat = k; break; end
      end
      chk("post rst latency", 64'(lat), 64'd33);
      chk("post rst result", result, ref_div(1'b0, 32'd1234567, 32'd89));
      start = 1'b0;
      @(negedge clk);

      // Random divides against the model
      for (int i = 0; i < 40; i++) begin
         logic        s;
         logic [31:0] a, b;
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(0, 15));
            1:       b = -32'($urandom_range(1, 15));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         do_div(s, a, b, ref_div(s, a, b), $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
